// File: rtl/oled_fb_reader.sv
// rtl/oled_fb_reader.sv - serves cropped/decimated RGB565 frame-buffer pixels to a 96x64 OLED and freezes capture while it scans.
// Optional OLED_FB_SWAP_RB_EN: swap red and blue fields for BGR-wired panels.
`timescale 1ns/1ps
module oled_fb_reader #(
  parameter int c_img_cols    = 320,
  parameter int c_img_rows    = 240,
  parameter int c_img_pxls    = c_img_cols * c_img_rows,
  parameter int c_nb_img_pxls = 17,
  parameter int c_nb_buf      = 16,
  parameter int c_oled_cols   = 96,
  parameter int c_oled_rows   = 64,
  parameter int c_dec         = 3,
  parameter int c_col_off     = 16,
  parameter int c_row_off     = 24
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cam_vsync,
  input  logic                     cap_we_in,
  output logic                     cap_we_out,
  input  logic [6:0]               oled_x,
  input  logic [5:0]               oled_y,
  input  logic                     next_pixel,
  output logic [c_nb_img_pxls-1:0] fb_addr,
  input  logic [c_nb_buf-1:0]      fb_pxl,
  output logic [15:0]              color,
  output logic                     locked
);

  localparam int c_nb_calc = c_nb_img_pxls + 1;

  typedef enum logic [1:0] {
    st_resume,
    st_capture,
    st_hold,
    st_scan
  } state_t;

  state_t state;

  logic vs_s1, vs_s2, vs_s3;
  logic vs_rise;
  logic frame_end;

  logic [c_nb_calc-1:0] x_ext, y_ext, addr_calc;

  logic [4:0] r5, g5;
  logic [5:0] b6;
  logic       unused_pxl_lsb;

  // VSYNC is asynchronous: two stages to resolve metastability, a third for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_s1 <= 1'b0;
      vs_s2 <= 1'b0;
      vs_s3 <= 1'b0;
    end else begin
      vs_s1 <= cam_vsync;
      vs_s2 <= vs_s1;
      vs_s3 <= vs_s2;
    end
  end

  assign vs_rise   = vs_s2 & ~vs_s3;
  assign frame_end = next_pixel
                   && (oled_x == 7'(c_oled_cols - 1))
                   && (oled_y == 6'(c_oled_rows - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= st_resume;
      locked <= 1'b0;
    end else begin
      case (state)
        st_resume: begin
          if (vs_rise) state <= st_capture;
        end
        st_capture: begin
          if (vs_rise) begin
            state  <= st_hold;
            locked <= 1'b1;
          end
        end
        st_hold: begin
          if (frame_end) state <= st_scan;
        end
        st_scan: begin
          // A vs_rise coinciding with frame_end here is dropped; RESUME waits for the next one.
          if (frame_end) begin
            state  <= st_resume;
            locked <= 1'b0;
          end
        end
        default: begin
          state  <= st_resume;
          locked <= 1'b0;
        end
      endcase
    end
  end

  assign cap_we_out = cap_we_in & (state == st_capture);

  // One spare bit so an out-of-range offset is seen rather than wrapped before the clamp.
  assign x_ext     = c_nb_calc'(oled_x);
  assign y_ext     = c_nb_calc'(oled_y);
  assign addr_calc = (y_ext * c_nb_calc'(c_dec) + c_nb_calc'(c_row_off)) * c_nb_calc'(c_img_cols)
                   + x_ext * c_nb_calc'(c_dec) + c_nb_calc'(c_col_off);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fb_addr <= '0;
    end else if (addr_calc >= c_nb_calc'(c_img_pxls)) begin
      fb_addr <= c_nb_img_pxls'(c_img_pxls - 1);
    end else begin
      fb_addr <= addr_calc[c_nb_img_pxls-1:0];
    end
  end

  // Buffer word is {r5,g5,b6}; the panel wants 6 bits of green, so green gains its MSB and blue drops its LSB.
  assign r5             = fb_pxl[15:11];
  assign g5             = fb_pxl[10:6];
  assign b6             = fb_pxl[5:0];
  assign unused_pxl_lsb = fb_pxl[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      color <= 16'h0000;
    end else begin
`ifdef OLED_FB_SWAP_RB_EN
      color <= {b6[5:1], g5, g5[4], r5};
`else
      color <= {r5, g5, g5[4], b6[5:1]};
`endif
    end
  end

endmodule

// File: tb/tb_oled_fb_reader.sv
// tb/tb_oled_fb_reader.sv - randomized self-checking bench for oled_fb_reader against a behavioural model.
`timescale 1ns/1ps
module tb_oled_fb_reader;

  localparam int img_cols = 320;
  localparam int img_pxls = 76800;
  localparam int m_resume  = 0;
  localparam int m_capture = 1;
  localparam int m_hold    = 2;
  localparam int m_scan    = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cam_vsync = 1'b0;
  logic        cap_we_in = 1'b0;
  logic        next_pixel = 1'b0;
  logic [6:0]  oled_x = '0;
  logic [5:0]  oled_y = '0;
  logic [15:0] fb_pxl = '0;
  logic [16:0] fb_addr, fb_addr2;
  logic [15:0] color, color2;
  logic        cap_we_out, cap_we_out2, locked, locked2;

  logic [15:0] mem [0:img_pxls-1];

  int checks = 0;
  int errors = 0;

  int       m_state = m_resume;
  bit [2:0] m_hist  = '0;
  int       m_addr  = 0;
  int       m_addr2 = 0;
  int       m_pxl   = 0;
  int       m_color = 0;

  oled_fb_reader dut (
    .clk(clk), .rst(rst), .cam_vsync(cam_vsync), .cap_we_in(cap_we_in), .cap_we_out(cap_we_out),
    .oled_x(oled_x), .oled_y(oled_y), .next_pixel(next_pixel), .fb_addr(fb_addr),
    .fb_pxl(fb_pxl), .color(color), .locked(locked)
  );

  oled_fb_reader #(.c_row_off(200)) dut_clamp (
    .clk(clk), .rst(rst), .cam_vsync(cam_vsync), .cap_we_in(cap_we_in), .cap_we_out(cap_we_out2),
    .oled_x(oled_x), .oled_y(oled_y), .next_pixel(next_pixel), .fb_addr(fb_addr2),
    .fb_pxl(fb_pxl), .color(color2), .locked(locked2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) fb_pxl <= mem[fb_addr];

  function automatic int exp_addr(input int x, input int y, input int row_off);
    int a;
    a = (y * 3 + row_off) * img_cols + x * 3 + 16;
    if (a >= img_pxls) a = img_pxls - 1;
    return a;
  endfunction

  function automatic int exp_color(input int p);
    int r, g, b;
    r = (p >> 11) & 31;
    g = (p >> 6) & 31;
    b = p & 63;
`ifdef OLED_FB_SWAP_RB_EN
    return ((b >> 1) << 11) | (g << 6) | ((g >> 4) << 5) | r;
`else
    return (r << 11) | (g << 6) | ((g >> 4) << 5) | (b >> 1);
`endif
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge rst) begin
    m_state = m_resume;
    m_hist  = '0;
    m_addr  = 0;
    m_addr2 = 0;
    m_color = 0;
  end

  always @(posedge clk) begin
    bit rise, fe;
    if (rst) begin
      m_color = 0;
      m_pxl   = mem[m_addr];
      m_addr  = 0;
      m_addr2 = 0;
      m_state = m_resume;
      m_hist  = '0;
    end else begin
      rise = m_hist[1] && !m_hist[2];
      fe   = next_pixel && oled_x == 95 && oled_y == 63;
      case (m_state)
        m_resume:  if (rise) m_state = m_capture;
        m_capture: if (rise) m_state = m_hold;
        m_hold:    if (fe)   m_state = m_scan;
        default:   if (fe)   m_state = m_resume;
      endcase
      m_hist  = {m_hist[1:0], cam_vsync};
      m_color = exp_color(m_pxl);
      m_pxl   = mem[m_addr];
      m_addr  = exp_addr(oled_x, oled_y, 24);
      m_addr2 = exp_addr(oled_x, oled_y, 200);
    end
  end

  always @(posedge clk) begin
    #3;
    chk("fb_addr", fb_addr, m_addr);
    chk("fb_addr_clamp_inst", fb_addr2, m_addr2);
    chk("color", color, m_color);
    chk("color_clamp_inst", color2, m_color);
    chk("locked", locked, (m_state == m_hold || m_state == m_scan) ? 1 : 0);
    chk("locked_clamp_inst", locked2, (m_state == m_hold || m_state == m_scan) ? 1 : 0);
    chk("cap_we_out", cap_we_out, (cap_we_in && m_state == m_capture) ? 1 : 0);
    chk("cap_we_out_clamp_inst", cap_we_out2, (cap_we_in && m_state == m_capture) ? 1 : 0);
  end

  task automatic rand_cycle();
    @(negedge clk);
    oled_x     = 7'($urandom_range(0, 95));
    oled_y     = 6'($urandom_range(0, 63));
    next_pixel = 1'b0;
    cap_we_in  = 1'($urandom);
  endtask

  task automatic vsync_pulse();
    @(negedge clk);
    cam_vsync = 1'b1;
    repeat (6) rand_cycle();
    cam_vsync = 1'b0;
    repeat (6) rand_cycle();
  endtask

  task automatic frame_end();
    @(negedge clk);
    oled_x     = 7'd95;
    oled_y     = 6'd63;
    next_pixel = 1'b1;
    @(negedge clk);
    next_pixel = 1'b0;
    repeat (4) rand_cycle();
  endtask

  task automatic probe_we(input string name, input int exp);
    cap_we_in = 1'b1;
    #1;
    chk(name, cap_we_out, exp);
  endtask

  initial begin
    int gap;
    for (int i = 0; i < img_pxls; i++) mem[i] = 16'($urandom);
    mem[7696] = 16'hFC21;

    rst       = 1'b1;
    cap_we_in = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_cap_we_out", cap_we_out, 0);
    chk("reset_locked", locked, 0);
    chk("reset_color", color, 0);
    chk("reset_fb_addr", fb_addr, 0);

    @(negedge clk);
    rst = 1'b0;
    repeat (8) rand_cycle();
    probe_we("resume_blocks_we", 0);

    @(negedge clk);
    oled_x = 7'd0;
    oled_y = 6'd0;
    @(negedge clk);
    chk("addr_origin", fb_addr, 7696);
    repeat (2) @(negedge clk);
`ifdef OLED_FB_SWAP_RB_EN
    chk("color_fc21", color, 16'h843F);
`else
    chk("color_fc21", color, 16'hFC30);
`endif
    oled_x = 7'd95;
    oled_y = 6'd63;
    @(negedge clk);
    chk("addr_corner", fb_addr, 68461);
    chk("addr_clamped", fb_addr2, 76799);

    vsync_pulse();
    probe_we("capture_we_high", 1);
    cap_we_in = 1'b0;
    #1;
    chk("capture_we_low", cap_we_out, 0);
    vsync_pulse();
    chk("hold_locked", locked, 1);
    probe_we("hold_blocks_we", 0);
    frame_end();
    chk("scan_locked", locked, 1);
    vsync_pulse();
    chk("scan_ignores_vsync", locked, 1);
    frame_end();
    chk("resume_unlocked", locked, 0);
    probe_we("resume_after_scan_we", 0);
    vsync_pulse();
    probe_we("recapture_we", 1);

    vsync_pulse();
    frame_end();
    chk("scan_before_coincide", locked, 1);
    @(negedge clk);
    cam_vsync = 1'b1;
    @(negedge clk);
    @(negedge clk);
    oled_x     = 7'd95;
    oled_y     = 6'd63;
    next_pixel = 1'b1;
    @(negedge clk);
    next_pixel = 1'b0;
    chk("coincide_unlocked", locked, 0);
    repeat (6) rand_cycle();
    cam_vsync = 1'b0;
    repeat (6) rand_cycle();
    probe_we("coincide_rise_dropped", 0);
    vsync_pulse();
    probe_we("coincide_next_rise", 1);

    gap = 0;
    for (int i = 0; i < 3000; i++) begin
      rand_cycle();
      if (gap >= 4 && $urandom_range(0, 2) == 0) begin
        next_pixel = 1'b1;
        gap = 0;
        if ($urandom_range(0, 2) == 0) begin
          oled_x = 7'd95;
          oled_y = 6'd63;
        end
      end
      gap++;
      if ($urandom_range(0, 39) == 0) cam_vsync = ~cam_vsync;
    end

    @(negedge clk);
    cam_vsync  = 1'b0;
    next_pixel = 1'b0;
    rst        = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) rand_cycle();
    vsync_pulse();
    vsync_pulse();
    frame_end();
    chk("pre_reset_scan", locked, 1);
    @(negedge clk);
    cap_we_in = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_locked", locked, 0);
    chk("async_rst_we", cap_we_out, 0);
    chk("async_rst_addr", fb_addr, 0);
    chk("async_rst_color", color, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) rand_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
